// File: rtl/net_sequencer.sv
// Pass scheduler for a chain of layer engines sharing one multiplier and one weight RAM.
// Starts layers one at a time (ascending forward, descending backward) and handshakes on ready.
module net_sequencer #(
    parameter int LAYERS      = 3,
    parameter int ACK_TIMEOUT = 15,
    parameter int LAYER_W     = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               run_f,
    input  logic               run_b,
    input  logic               abort,
    input  logic [LAYERS-1:0]  layer_ready,
    output logic [LAYERS-1:0]  layer_enable,
    output logic [LAYERS-1:0]  layer_start_f,
    output logic [LAYERS-1:0]  layer_start_b,
    output logic [LAYERS-1:0]  layer_go,
    output logic [LAYER_W-1:0] sel,
    output logic               busy,
    output logic               dir_b,
    output logic               done,
    output logic               err
);

    localparam int                 CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [LAYER_W-1:0] LAST_IDX = LAYER_W'(LAYERS - 1);
    localparam logic [CNT_W-1:0]   ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [LAYER_W-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_ack_cnt, w_ack_cnt_nxt;
    logic               r_dir_b, w_dir_b_nxt;
    logic               r_err, w_err_nxt;
    logic               w_rdy_act;
    logic               w_last;
    logic               w_active;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ack_cnt <= '0;
            r_dir_b   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_ack_cnt <= w_ack_cnt_nxt;
            r_dir_b   <= w_dir_b_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Ready of the currently selected layer; idx never exceeds LAYERS-1.
    always_comb begin
        w_rdy_act = 1'b0;
        for (int i = 0; i < LAYERS; i++) begin
            if (r_idx == LAYER_W'(i)) begin
                w_rdy_act = layer_ready[i];
            end
        end
    end

    assign w_last = r_dir_b ? (r_idx == '0) : (r_idx == LAST_IDX);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_ack_cnt_nxt = r_ack_cnt;
        w_dir_b_nxt   = r_dir_b;
        w_err_nxt     = r_err;
        case (r_state)
            S_IDLE: begin
                if (run_f) begin
                    w_dir_b_nxt = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_START;
                end else if (run_b) begin
                    w_dir_b_nxt = 1'b1;
                    w_idx_nxt   = LAST_IDX;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_ack_cnt_nxt = '0;
                w_state_nxt   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!w_rdy_act) begin
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt + 1'b1;
                    if (r_ack_cnt == ACK_LAST) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (w_rdy_act) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_dir_b ? (r_idx - 1'b1) : (r_idx + 1'b1);
                        w_state_nxt = S_START;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERROR: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every transition; in IDLE it only clears the error flag.
        if (abort) begin
            w_err_nxt = 1'b0;
            if (r_state != S_IDLE) begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = r_idx;
                w_dir_b_nxt = r_dir_b;
            end
        end
    end

    assign w_active = (r_state == S_START) || (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE);

    always_comb begin
        layer_enable  = '0;
        layer_start_f = '0;
        layer_start_b = '0;
        layer_go      = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (r_idx == LAYER_W'(i)) begin
                layer_enable[i]  = w_active;
                layer_start_f[i] = (r_state == S_START) && !r_dir_b;
                layer_start_b[i] = (r_state == S_START) && r_dir_b;
                layer_go[i]      = (r_state == S_WAIT_DONE);
            end
        end
    end

    assign sel   = r_idx;
    assign busy  = (r_state != S_IDLE);
    assign dir_b = r_dir_b;
    assign done  = (r_state == S_DONE);
    assign err   = r_err;

endmodule

// File: tb/tb_net_sequencer.sv
// Bench for net_sequencer: behavioural layer engines plus a cycle-timing model of whole passes.
module tb_net_sequencer;
    localparam int LAYERS = 3;
    localparam int ACK    = 4;
    localparam int LW     = 2;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              run_f = 1'b0, run_b = 1'b0, abort = 1'b0;
    logic [LAYERS-1:0] layer_ready, layer_enable, layer_start_f, layer_start_b, layer_go;
    logic [LW-1:0]     sel;
    logic              busy, dir_b, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dur[LAYERS];
    bit stuck[LAYERS];
    int lcnt[LAYERS];

    int                q_scyc[$];
    int                q_sidx[$];
    bit                q_sdir[$];
    logic [LAYERS-1:0] q_sen[$];
    int                q_ssel[$];
    int                q_done[$];
    int                go_cycles;
    int                en_cycles;

    net_sequencer #(.LAYERS(LAYERS), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .nreset(nreset), .run_f(run_f), .run_b(run_b), .abort(abort),
        .layer_ready(layer_ready), .layer_enable(layer_enable),
        .layer_start_f(layer_start_f), .layer_start_b(layer_start_b), .layer_go(layer_go),
        .sel(sel), .busy(busy), .dir_b(dir_b), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Layer engine: ready drops the cycle after a start and stays low for dur cycles.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < LAYERS; i++) lcnt[i] <= 0;
        end else begin
            for (int i = 0; i < LAYERS; i++) begin
                if ((layer_start_f[i] || layer_start_b[i]) && !stuck[i]) lcnt[i] <= dur[i];
                else if (lcnt[i] > 0) lcnt[i] <= lcnt[i] - 1;
            end
        end
    end

    always_comb begin
        layer_ready = '0;
        for (int i = 0; i < LAYERS; i++) layer_ready[i] = (lcnt[i] == 0);
    end

    always @(negedge clk) begin : mon
        logic [LAYERS-1:0] st;
        int ix;
        if (nreset) begin
            st = layer_start_f | layer_start_b;
            if (st != 0) begin
                ix = -1;
                for (int i = 0; i < LAYERS; i++) if (st[i]) ix = i;
                q_scyc.push_back(cyc);
                q_sidx.push_back(ix);
                q_sdir.push_back(|layer_start_b);
                q_sen.push_back(layer_enable);
                q_ssel.push_back(int'(sel));
            end
            if (done) q_done.push_back(cyc);
            if (layer_go != 0) go_cycles++;
            if (layer_enable != 0) en_cycles++;
            checks++;
            if ($countones(layer_enable) > 1 || $countones(st) > 1 || (st & ~layer_enable) != 0 ||
                (layer_go & ~layer_enable) != 0 || (layer_go & st) != 0 ||
                (layer_enable != 0 && layer_enable != (LAYERS'(1) << sel))) begin
                errors++;
                $display("FAIL invariant cyc=%0d en=%b sf=%b sb=%b go=%b sel=%0d", cyc,
                         layer_enable, layer_start_f, layer_start_b, layer_go, sel);
            end
        end
    end

    task automatic clear_mon();
        q_scyc.delete(); q_sidx.delete(); q_sdir.delete(); q_sen.delete(); q_ssel.delete();
        q_done.delete();
        go_cycles = 0;
        en_cycles = 0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Full pass against the timing model: layer k+1 starts dur[k]+2 cycles after layer k.
    task automatic run_pass(input bit dir, input bit both, input bit extra, input string name);
        int es_cyc[LAYERS];
        int es_idx[LAYERS];
        int t, t0, ix, sum_go, edone, xat;
        bit fin;
        clear_mon();
        t0 = cyc;
        t = t0 + 1;
        sum_go = 0;
        for (int k = 0; k < LAYERS; k++) begin
            ix = dir ? (LAYERS - 1 - k) : k;
            es_cyc[k] = t;
            es_idx[k] = ix;
            t += dur[ix] + 2;
            sum_go += dur[ix];
        end
        edone = t;
        xat = $urandom_range(2, 6);
        run_f = !dir;
        run_b = dir | both;
        fin = 1'b0;
        for (int j = 1; j < 400 && !fin; j++) begin
            @(negedge clk);
            if (j == 1) begin run_f = 1'b0; run_b = 1'b0; end
            if (extra && j == xat) begin run_f = 1'($urandom); run_b = 1'b1; end
            if (extra && j == xat + 1) begin run_f = 1'b0; run_b = 1'b0; end
            if (j > xat + 1 && !busy && q_done.size() > 0) fin = 1'b1;
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL %s pass_end busy=%b dones=%0d required done then idle", name, busy, q_done.size()); end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s restart busy=%b required 0", name, busy); end
        checks++;
        if (q_scyc.size() != LAYERS) begin errors++; $display("FAIL %s start_count got=%0d required=%0d", name, q_scyc.size(), LAYERS); end
        for (int k = 0; k < LAYERS && k < q_scyc.size(); k++) begin
            checks++;
            if (q_scyc[k] != es_cyc[k] || q_sidx[k] != es_idx[k] || q_sdir[k] != dir) begin
                errors++;
                $display("FAIL %s start%0d cyc=%0d idx=%0d dir=%0d required cyc=%0d idx=%0d dir=%0d", name, k,
                         q_scyc[k], q_sidx[k], q_sdir[k], es_cyc[k], es_idx[k], dir);
            end
            checks++;
            if (q_sen[k] !== (LAYERS'(1) << es_idx[k]) || q_ssel[k] != es_idx[k]) begin
                errors++;
                $display("FAIL %s enable%0d en=%b sel=%0d required idx=%0d", name, k, q_sen[k], q_ssel[k], es_idx[k]);
            end
        end
        checks++;
        if (q_done.size() != 1 || (q_done.size() > 0 && q_done[0] != edone)) begin
            errors++;
            $display("FAIL %s done pulses=%0d first=%0d required one at %0d", name, q_done.size(),
                     (q_done.size() > 0) ? q_done[0] : -1, edone);
        end
        checks++;
        if (go_cycles != sum_go || en_cycles != edone - t0 - 1) begin
            errors++;
            $display("FAIL %s occupancy go=%0d en=%0d required go=%0d en=%0d", name, go_cycles, en_cycles, sum_go, edone - t0 - 1);
        end
        checks++;
        if (dir_b !== dir || err !== 1'b0) begin errors++; $display("FAIL %s dir_b=%b err=%b required dir_b=%b err=0", name, dir_b, err, dir); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({layer_enable, layer_start_f, layer_start_b, layer_go, sel, busy, dir_b, done, err} !== '0) begin
            errors++; $display("FAIL reset_hold en=%b go=%b sel=%0d busy=%b required all 0", layer_enable, layer_go, sel, busy);
        end
        nreset = 1'b1;
        @(negedge clk);
        run_b = 1'b1;
        @(negedge clk);
        run_b = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dir_b !== 1'b1 || sel !== 2'd2 || layer_go !== 3'b100) begin
            errors++; $display("FAIL reset_prepass busy=%b dir_b=%b sel=%0d go=%b required 1 1 2 100", busy, dir_b, sel, layer_go);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if ({layer_enable, layer_start_f, layer_start_b, layer_go, sel, busy, dir_b, done, err} !== '0) begin
            errors++; $display("FAIL reset_async en=%b go=%b sel=%0d busy=%b dir_b=%b required all 0", layer_enable, layer_go, sel, busy, dir_b);
        end
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sel !== 2'd0 || err !== 1'b0 || dir_b !== 1'b0) begin
            errors++; $display("FAIL reset_release busy=%b sel=%0d err=%b dir_b=%b required 0", busy, sel, err, dir_b);
        end
    endtask

    task automatic test_forward();
        for (int i = 0; i < LAYERS; i++) dur[i] = 5;
        run_pass(1'b0, 1'b0, 1'b0, "forward");
    endtask

    task automatic test_backward();
        for (int i = 0; i < LAYERS; i++) dur[i] = 5;
        run_pass(1'b1, 1'b0, 1'b0, "backward");
    endtask

    task automatic test_both_and_ignored();
        for (int i = 0; i < LAYERS; i++) dur[i] = 3 + i;
        run_pass(1'b0, 1'b1, 1'b1, "both_ignored");
    endtask

    task automatic test_timeout();
        int t0, s1;
        for (int i = 0; i < LAYERS; i++) dur[i] = 5;
        stuck[1] = 1'b1;
        clear_mon();
        t0 = cyc;
        run_f = 1'b1;
        @(negedge clk);
        run_f = 1'b0;
        s1 = t0 + 1 + dur[0] + 2;
        wait_cyc(s1 + 4);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || layer_enable !== 3'b010) begin
            errors++; $display("FAIL timeout_waitack busy=%b err=%b en=%b required 1 0 010", busy, err, layer_enable);
        end
        wait_cyc(s1 + 6);
        checks++;
        if (busy !== 1'b1 || err !== 1'b1 || layer_enable !== 3'b000 || layer_go !== 3'b000 || done !== 1'b0) begin
            errors++; $display("FAIL timeout_error busy=%b err=%b en=%b go=%b done=%b required 1 1 000 000 0", busy, err, layer_enable, layer_go, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || q_scyc.size() != 2) begin
            errors++; $display("FAIL timeout_sticky err=%b busy=%b starts=%0d required 1 1 2", err, busy, q_scyc.size());
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL timeout_abort busy=%b err=%b required 0 0", busy, err);
        end
        stuck[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q_done.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_nodone dones=%0d busy=%b required 0 0", q_done.size(), busy);
        end
    endtask

    task automatic test_abort();
        int t0, s1;
        for (int i = 0; i < LAYERS; i++) dur[i] = 5;
        clear_mon();
        t0 = cyc;
        run_f = 1'b1;
        @(negedge clk);
        run_f = 1'b0;
        s1 = t0 + 1 + dur[0] + 2;
        wait_cyc(s1 + 3);
        checks++;
        if (layer_go !== 3'b010 || sel !== 2'd1) begin
            errors++; $display("FAIL abort_pre go=%b sel=%0d required 010 1", layer_go, sel);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || layer_enable !== 3'b000 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle busy=%b en=%b done=%b required 0 000 0", busy, layer_enable, done);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (q_done.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_nodone dones=%0d busy=%b required 0 0", q_done.size(), busy);
        end
        run_pass(1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        bit d, b, x;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < LAYERS; i++) dur[i] = $urandom_range(1, 8);
            d = 1'($urandom);
            b = d ? 1'b0 : 1'($urandom);
            x = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_pass(d, b, x, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < LAYERS; i++) begin
            dur[i] = 5;
            stuck[i] = 1'b0;
        end
        test_reset();
        test_forward();
        test_backward();
        test_both_and_ignored();
        test_timeout();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
